boot_sequencer: RTL

//  Boot loader controller placed between spi_microsd and on-chip instruction memory.

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_timeout_ctr.sv | 40 ++++
 rtl/boot_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared state encoding and default sizing for the SD-card boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_REQ       = 3'd2,
    ST_RECV      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } boot_state_t;

  localparam int SECTOR_BYTES          = 512;
  localparam int WORD_BYTES            = 4;
  localparam int DEFAULT_WORDS_PER_SEC = SECTOR_BYTES / WORD_BYTES;
  localparam int DEFAULT_TIMEOUT_CYC   = 1 << 20;

endpackage

// File: rtl/boot_timeout_ctr.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags expiry.
module boot_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is flagged during the TIMEOUT_CYC-th enabled cycle after a clear,
  // so the consumer's state change lands exactly TIMEOUT_CYC edges later.
  assign expired_o = en_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot loader: copies NUM_WORDS words from consecutive SD sectors into instruction
// memory, then releases the CPU from reset. Errors and timeouts are terminal.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter logic [31:0] BOOT_SECTOR   = 32'd0,
  parameter int          NUM_WORDS     = 1024,
  parameter int          WORDS_PER_SEC = DEFAULT_WORDS_PER_SEC,
  parameter int          MEM_AW        = 10,
  parameter int          TIMEOUT_CYC   = DEFAULT_TIMEOUT_CYC
) (
  input  logic              control_clk_i,
  input  logic              control_rst_i,
  input  logic              boot_start_i,
  input  logic              sd_init_done_i,
  output logic [31:0]       sd_address_o,
  output logic              sd_re_o,
  input  logic [31:0]       sd_data_i,
  input  logic              sd_valid_i,
  input  logic              sd_error_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_rst_o,
  output logic              boot_done_o,
  output logic              boot_error_o,
  output logic [MEM_AW:0]   words_loaded_o,
  output boot_state_t       dbg_state_o
);

  localparam int SW = $clog2(WORDS_PER_SEC + 1);
  localparam logic [MEM_AW:0] LAST_WORD   = (MEM_AW + 1)'(NUM_WORDS - 1);
  localparam logic [MEM_AW:0] WORD_ONE    = (MEM_AW + 1)'(1);
  localparam logic [SW-1:0]   LAST_IN_SEC = SW'(WORDS_PER_SEC - 1);
  localparam logic [SW-1:0]   SEC_ONE     = SW'(1);

  boot_state_t       state_q, state_d;
  logic [31:0]       sector_q, sector_d;
  logic [MEM_AW:0]   word_cnt_q, word_cnt_d;
  logic [SW-1:0]     sec_word_q, sec_word_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_error_q, boot_error_d;
  logic              tmo_expired;

  // SD side has no back-pressure: sd_re_o is a single-cycle request, and every
  // sd_valid_i cycle delivers exactly one word that must be taken that cycle.
  assign sd_re_o        = (state_q == ST_REQ);
  assign sd_address_o   = BOOT_SECTOR + sector_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign boot_done_o    = boot_done_q;
  assign boot_error_o   = boot_error_q;
  assign words_loaded_o = word_cnt_q;
  assign dbg_state_o    = state_q;

  boot_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (control_clk_i),
    .rst      (control_rst_i),
    .clear_i  (sd_re_o || sd_valid_i),
    .en_i     (state_q == ST_RECV),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    sector_d   = sector_q;
    word_cnt_d = word_cnt_q;
    sec_word_d = sec_word_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      ST_IDLE:      if (boot_start_i) state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: if (sd_init_done_i) state_d = ST_REQ;
      ST_REQ:       state_d = sd_error_i ? ST_ERROR : ST_RECV;
      ST_RECV: begin
        // An error strobe beats a word in the same cycle; a word beats the watchdog.
        if (sd_error_i) begin
          state_d = ST_ERROR;
        end else if (sd_valid_i) begin
          mem_we_d   = 1'b1;
          mem_addr_d = word_cnt_q[MEM_AW-1:0];
          mem_data_d = sd_data_i;
          word_cnt_d = word_cnt_q + WORD_ONE;
          if (word_cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end else if (sec_word_q == LAST_IN_SEC) begin
            sec_word_d = '0;
            sector_d   = sector_q + 32'd1;
            state_d    = ST_REQ;
          end else begin
            sec_word_d = sec_word_q + SEC_ONE;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
        end
      end
      default: ;
    endcase
    cpu_rst_d    = (state_q != ST_DONE);
    boot_done_d  = (state_q == ST_DONE);
    boot_error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge control_clk_i or posedge control_rst_i) begin
    if (control_rst_i) begin
      state_q      <= ST_IDLE;
      sector_q     <= '0;
      word_cnt_q   <= '0;
      sec_word_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      cpu_rst_q    <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sector_q     <= sector_d;
      word_cnt_q   <= word_cnt_d;
      sec_word_q   <= sec_word_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      cpu_rst_q    <= cpu_rst_d;
      boot_done_q  <= boot_done_d;
      boot_error_q <= boot_error_d;
    end
  end

endmodule
